// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: request/response bundle for sync_fifo_param.
// master drives requests and err_clr; slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_o;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en,
    output data_in,
    output rd_en,
    output err_clr,
    input  data_o,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  wr_en,
    input  data_in,
    input  rd_en,
    input  err_clr,
    output data_o,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: synchronous FIFO, exact flags, registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int AF_LVL = 48,
  parameter int AE_LVL = 16
) (
  input logic             clk,
  input logic             reset_n,
  sync_fifo_param_if.slave f
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_C =
    (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C =
    (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   cnt_nxt;
  logic [DATA_W-1:0] dout_q;
  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  assign wr_idx = wr_ptr[ADDR_W-1:0];
  assign rd_idx = rd_ptr[ADDR_W-1:0];

  // Flags come from registered pointers/count only.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_idx == rd_idx) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign wr_acc = f.wr_en && !full_w;
  assign rd_acc = f.rd_en && !empty_w;

  assign f.full         = full_w;
  assign f.empty        = empty_w;
  assign f.almost_full  = (count_q >= AF_C);
  assign f.almost_empty = (count_q <= AE_C);
  assign f.count        = count_q;
  assign f.data_o       = dout_q;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= f.data_in;
    end
  end

  // Pointers advance only on accepted operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy next-state from accepted ops.
  always_comb begin
    cnt_nxt = count_q;
    unique case (1'b1)
      (wr_acc && !rd_acc): cnt_nxt = count_q + 1'b1;
      (rd_acc && !wr_acc): cnt_nxt = count_q - 1'b1;
      default: ;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= cnt_nxt;
    end
  end

  // Read data loads on accepted read, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_idx];
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky errors; a new error beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (f.wr_en && full_w) ||
               (ovf_q && !f.err_clr);
      unf_q <= (f.rd_en && empty_w) ||
               (unf_q && !f.err_clr);
    end
  end

  assign f.overflow  = ovf_q;
  assign f.underflow = unf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = f.err_clr;
  assign f.overflow     = 1'b0;
  assign f.underflow    = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random checks of two FIFO configs
// against a queue model (default and 16x16 build).
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  sync_fifo_param_if #(.DATA_W(8),  .ADDR_W(6)) bus0 ();
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

  sync_fifo_param u0 (
    .clk(clk),
    .reset_n(reset_n),
    .f(bus0)
  );

  sync_fifo_param #(
    .DATA_W(16),
    .ADDR_W(4),
    .AF_LVL(12),
    .AE_LVL(2)
  ) u1 (
    .clk(clk),
    .reset_n(reset_n),
    .f(bus1)
  );

  always #5 clk = ~clk;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] dq[2];
  bit          ovm[2];
  bit          unm[2];

  function automatic int depth(int d);
    return d ? 16 : 64;
  endfunction
  function automatic int af_lvl(int d);
    return d ? 12 : 48;
  endfunction
  function automatic int ae_lvl(int d);
    return d ? 2 : 16;
  endfunction
  function automatic int qsize(int d);
    return d ? q1.size() : q0.size();
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus0.wr_en = 0; bus0.rd_en = 0;
    bus0.err_clr = 0; bus0.data_in = '0;
    bus1.wr_en = 0; bus1.rd_en = 0;
    bus1.err_clr = 0; bus1.data_in = '0;
  endtask

  task automatic check_all(int d);
    int n;
    n = qsize(d);
    chk($sformatf("u%0d.count", d),
        d ? 64'(bus1.count) : 64'(bus0.count), 64'(n));
    chk($sformatf("u%0d.full", d),
        d ? 64'(bus1.full) : 64'(bus0.full),
        64'(n == depth(d)));
    chk($sformatf("u%0d.empty", d),
        d ? 64'(bus1.empty) : 64'(bus0.empty),
        64'(n == 0));
    chk($sformatf("u%0d.afull", d),
        d ? 64'(bus1.almost_full) : 64'(bus0.almost_full),
        64'(n >= af_lvl(d)));
    chk($sformatf("u%0d.aempty", d),
        d ? 64'(bus1.almost_empty) : 64'(bus0.almost_empty),
        64'(n <= ae_lvl(d)));
    chk($sformatf("u%0d.data_o", d),
        d ? 64'(bus1.data_o) : 64'(bus0.data_o),
        64'(dq[d]));
    chk($sformatf("u%0d.overflow", d),
        d ? 64'(bus1.overflow) : 64'(bus0.overflow),
        64'(ovm[d]));
    chk($sformatf("u%0d.underflow", d),
        d ? 64'(bus1.underflow) : 64'(bus0.underflow),
        64'(unm[d]));
  endtask

  task automatic step(int d, bit w, logic [15:0] din,
                      bit r, bit c);
    int n;
    bit fm, em, wa, ra;
    n  = qsize(d);
    fm = (n == depth(d));
    em = (n == 0);
    wa = w && !fm;
    ra = r && !em;
    if (d == 0) begin
      bus0.wr_en = w; bus0.rd_en = r;
      bus0.err_clr = c; bus0.data_in = din[7:0];
    end else begin
      bus1.wr_en = w; bus1.rd_en = r;
      bus1.err_clr = c; bus1.data_in = din;
    end
    if (ERR) begin
      ovm[d] = (w && fm) || (ovm[d] && !c);
      unm[d] = (r && em) || (unm[d] && !c);
    end
    if (ra) dq[d] = d ? q1.pop_front() : q0.pop_front();
    if (wa) begin
      if (d == 0) q0.push_back({8'h00, din[7:0]});
      else q1.push_back(din);
    end
    @(posedge clk);
    #1;
    idle();
    check_all(d);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      dq[i] = '0; ovm[i] = 0; unm[i] = 0;
    end
  endtask

  initial begin
    logic [15:0] v;
    idle();
    reset_n = 1'b0;
    model_reset();
    #3;
    check_all(0);
    check_all(1);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // fill default config with 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 16'(i), 0, 0);
      if (i == 46) chk("af.pre", 64'(bus0.almost_full), 0);
      if (i == 47) chk("af.rise", 64'(bus0.almost_full), 1);
    end
    chk("fill.count", 64'(bus0.count), 64);
    chk("fill.full", 64'(bus0.full), 1);

    // write while full is dropped
    step(0, 1, 16'hAA, 0, 0);
    chk("ovf.count", 64'(bus0.count), 64);

    // drain in order
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 16'h0, 1, 0);
      chk("drain.data", 64'(bus0.data_o), 64'(i));
      if (i == 46) chk("ae.pre", 64'(bus0.almost_empty), 0);
      if (i == 47) chk("ae.rise", 64'(bus0.almost_empty), 1);
    end
    chk("drain.empty", 64'(bus0.empty), 1);

    // read while empty holds data_o
    step(0, 0, 16'h0, 1, 0);
    chk("unf.hold", 64'(bus0.data_o), 64'h3F);

    // clear sticky errors
    step(0, 0, 16'h0, 0, 1);
    chk("clr.ovf", 64'(bus0.overflow), 0);
    chk("clr.unf", 64'(bus0.underflow), 0);

    // simultaneous at empty: write only
    step(0, 1, 16'h77, 1, 0);
    chk("simE.count", 64'(bus0.count), 1);
    chk("simE.data", 64'(bus0.data_o), 64'h3F);

    // bring to 10, then 200 cycles of wr+rd across wrap
    for (int i = 0; i < 9; i++)
      step(0, 1, 16'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 200; i++)
      step(0, 1, 16'($urandom_range(0, 255)), 1, 0);
    chk("wrap.count", 64'(bus0.count), 10);

    // random traffic incl. errors and clears
    for (int i = 0; i < 400; i++)
      step(0, 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));

    // reset at count 30
    while (q0.size() > 0) step(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 30; i++)
      step(0, 1, 16'($urandom_range(0, 255)), 0, 0);
    chk("pre_rst.count", 64'(bus0.count), 30);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst.count", 64'(bus0.count), 0);
    chk("rst.empty", 64'(bus0.empty), 1);
    check_all(0);
    check_all(1);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 16'h5C, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    chk("rst.first", 64'(bus0.data_o), 64'h5C);

    // second config fill/drain
    for (int i = 0; i < 16; i++)
      step(1, 1, 16'(16'h1000 + i * 16'h0101), 0, 0);
    chk("u1.fill.full", 64'(bus1.full), 1);
    step(1, 1, 16'hAAAA, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 16'h0, 1, 0);
      v = 16'(16'h1000 + i * 16'h0101);
      chk("u1.drain.data", 64'(bus1.data_o), 64'(v));
    end
    step(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 300; i++)
      step(1, 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
